// File: rtl/aes_sched.sv
// rtl/aes_sched.sv - two-requester round-robin job scheduler in front of an aes_192 core
// Optional macro AES_SCHED_TIMEOUT_EN aborts a WAIT longer than TIMEOUT cycles with rsp_err.
`timescale 1ns/1ps
module aes_sched #(
  parameter int TIMEOUT = 255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_pt,
  input  logic [127:0] req1_pt,
  input  logic [191:0] req0_key,
  input  logic [191:0] req1_key,
  output logic         aes_start,
  output logic [127:0] aes_state,
  output logic [191:0] aes_key,
  input  logic [127:0] aes_out,
  input  logic         aes_out_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_ct,
  output logic         rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e       state_q, state_d;
  logic         pri_q, pri_d;  // 1: requester 1 wins a tie
  logic [127:0] pt_q, pt_d;
  logic [191:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;
  logic         id_q, id_d;
  logic         err_q, err_d;
  logic         any_req;
  logic         gnt1;
  logic         timed_out;

`ifdef AES_SCHED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timed_out = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timed_out      = 1'b0;
`endif

  assign any_req = req0_valid | req1_valid;
  assign gnt1    = req1_valid & (~req0_valid | pri_q);

  // Ready is gated by reset so a held request is never acknowledged while in reset.
  assign req0_ready = wb_rst_ni & (state_q == S_IDLE) & req0_valid & ~gnt1;
  assign req1_ready = wb_rst_ni & (state_q == S_IDLE) & gnt1;
  assign aes_start  = (state_q == S_ISSUE);
  assign rsp_valid  = (state_q == S_RESP);
  assign aes_state  = pt_q;
  assign aes_key    = key_q;
  assign rsp_id     = id_q;
  assign rsp_ct     = ct_q;
  assign rsp_err    = err_q;

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    pt_d    = pt_q;
    key_d   = key_q;
    ct_d    = ct_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          id_d    = gnt1;
          pt_d    = gnt1 ? req1_pt : req0_pt;
          key_d   = gnt1 ? req1_key : req0_key;
          pri_d   = ~gnt1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (aes_out_valid) begin
          ct_d    = aes_out;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timed_out) begin
          ct_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      pri_q   <= 1'b0;
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/aes_sched.md
AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles in WAIT before abort (1..255).
REQ-002 SHALL have port wb_clk_i  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port wb_rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester n has a job.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  job accepted this cycle.
REQ-006 SHALL have ports req0_pt/req1_pt  input  128  plaintext.
REQ-007 SHALL have ports req0_key/req1_key  input  192  AES-192 key.
REQ-008 SHALL have port aes_start  output  1  start to aes_192 core.
REQ-009 SHALL have port aes_state  output  128  registered plaintext to core.
REQ-010 SHALL have port aes_key  output  192  registered key to core.
REQ-011 SHALL have port aes_out  input  128  core ciphertext.
REQ-012 SHALL have port aes_out_valid  input  1  core result valid.
REQ-013 SHALL have port rsp_valid  output  1  result held for consumer.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-015 SHALL have port rsp_id  output  1  requester index of result.
REQ-016 SHALL have port rsp_ct  output  128  ciphertext.
REQ-017 SHALL have port rsp_err  output  1  result aborted by timeout (0 when AES_SCHED_TIMEOUT_EN undefined).

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one state per cycle minimum.
REQ-019 IDLE: any reqN_valid SHALL grant one requester, assert its reqN_ready for exactly that cycle, capture pt/key/id, go ISSUE.
REQ-020 Arbitration SHALL be round-robin: both valid -> grant requester not granted last; priority pointer updates only on grant; after reset requester 0 wins a tie.
REQ-021 reqN_ready SHALL be 0 in all states except the granting IDLE cycle; never both high.
REQ-022 ISSUE: aes_start SHALL be 1 for exactly one cycle, then go WAIT.
REQ-023 aes_state/aes_key SHALL remain stable from ISSUE until leaving WAIT.
REQ-024 WAIT: aes_out_valid=1 SHALL capture aes_out into rsp_ct, rsp_err=0, go RESP; aes_out_valid outside WAIT SHALL be ignored.
REQ-025 RESP: rsp_valid=1 with rsp_ct/rsp_id/rsp_err stable until rsp_ready=1; rsp_valid&rsp_ready SHALL return to IDLE next cycle.
REQ-026 Grant-to-rsp_valid latency SHALL be core latency + 3 cycles; RESP handshake to next grant SHALL be 1 cycle.
REQ-027 Requests withdrawn before grant SHALL be dropped silently; no queuing.

Reset
REQ-028 wb_rst_ni=0 SHALL immediately force IDLE, priority pointer to requester 0, reqN_ready=0, aes_start=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_ct=0, aes_state=0, aes_key=0, timeout counter=0.
REQ-029 Reset mid-WAIT/RESP SHALL discard the job; a later aes_out_valid SHALL be ignored.
REQ-030 Release SHALL be usable on the first following clock edge.

Configuration
REQ-031 Macro AES_SCHED_TIMEOUT_EN defined: 8-bit counter clears on ISSUE, increments each WAIT cycle; reaching TIMEOUT without aes_out_valid SHALL go RESP with rsp_err=1, rsp_ct=0; aes_out_valid on the same cycle SHALL win (rsp_err=0).
REQ-032 Macro undefined: no counter; WAIT held indefinitely; rsp_err tied 0; TIMEOUT unused.

Verification
REQ-033 Reset, req0_valid=1 pt=0x00112233445566778899aabbccddeeff key=0x000102...17 -> aes_start pulse 1 cycle, rsp_ct=0xdda97ca4864cdfe06eaf70a0ec0d7191, rsp_id=0, rsp_err=0.
REQ-034 req0 and req1 valid continuously for 4 jobs -> grant order 0,1,0,1; rsp_id follows.
REQ-035 rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_ct stable, no reqN_ready, no aes_start.
REQ-036 wb_rst_ni low in WAIT, core asserts aes_out_valid 2 cycles after release -> rsp_valid stays 0, state IDLE.
REQ-037 AES_SCHED_TIMEOUT_EN, TIMEOUT=16, core never valid -> rsp_valid after 16 WAIT cycles, rsp_err=1, rsp_ct=0.
REQ-038 aes_out_valid pulsed in IDLE with no request -> no rsp_valid, no state change.
